// File: rtl/map_writer.sv
// 20x15 tile map owner: single-cell writes, conditional writes, whole-map fill
// and whole-map value count, all issued through one valid/ready command port.
module map_writer (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [4:0]   cmd_h,
  input  logic [4:0]   cmd_v,
  input  logic [2:0]   cmd_data,
  output logic         rsp_valid,
  output logic [8:0]   rsp_data,
  output logic         rsp_err,
  output logic [0:899] map
);

  localparam logic [1:0] OP_WRITE      = 2'd0;
  localparam logic [1:0] OP_FILL       = 2'd1;
  localparam logic [1:0] OP_WRITE_NONE = 2'd2;
  localparam logic [1:0] OP_COUNT      = 2'd3;
  localparam logic [8:0] LAST_IDX      = 9'd299;

  typedef enum logic [1:0] {IDLE = 2'd0, SWEEP = 2'd1, DONE = 2'd2} state_t;

  state_t        state_r, state_n;
  logic [0:899]  map_r;
  logic [8:0]    idx_r;
  logic [8:0]    cnt_r;
  logic [2:0]    val_r;
  logic          is_count_r;
  logic          ready_r;
  logic          rsp_valid_r;
  logic [8:0]    rsp_data_r;
  logic          rsp_err_r;

  logic          accept_s;
  logic          in_range_s;
  logic [8:0]    cell_idx_s;
  logic [9:0]    wr_off_s;
  logic [2:0]    old_cell_s;
  logic [9:0]    sw_off_s;
  logic [2:0]    sw_cell_s;
  logic          match_s;

  assign cmd_ready = ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_err   = rsp_err_r;
  assign map       = map_r;

  // Address decode; out-of-range coordinates are steered to offset 0 and never written.
  always_comb begin
    in_range_s = (cmd_h < 5'd20) && (cmd_v < 5'd15);
    cell_idx_s = {4'd0, cmd_h} + ({4'd0, cmd_v} * 9'd20);
    if (in_range_s) begin
      wr_off_s = 10'd3 * {1'b0, cell_idx_s};
    end else begin
      wr_off_s = 10'd0;
    end
    old_cell_s = map_r[wr_off_s +: 3];
    sw_off_s   = 10'd3 * {1'b0, idx_r};
    sw_cell_s  = map_r[sw_off_s +: 3];
    match_s    = (sw_cell_s == val_r);
  end

  // Next-state logic and command acceptance.
  always_comb begin
    state_n  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          accept_s = 1'b1;
          if ((cmd_op == OP_FILL) || (cmd_op == OP_COUNT)) begin
            state_n = SWEEP;
          end else begin
            state_n = IDLE;
          end
        end else begin
          state_n = IDLE;
        end
      end
      SWEEP: begin
        if (idx_r == LAST_IDX) begin
          state_n = DONE;
        end else begin
          state_n = SWEEP;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, map storage, sweep datapath and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      map_r       <= '0;
      idx_r       <= 9'd0;
      cnt_r       <= 9'd0;
      val_r       <= 3'd0;
      is_count_r  <= 1'b0;
      ready_r     <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 9'd0;
      rsp_err_r   <= 1'b0;
    end else begin
      state_r     <= state_n;
      ready_r     <= (state_n == IDLE);
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 9'd0;
      rsp_err_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            case (cmd_op)
              OP_WRITE, OP_WRITE_NONE: begin
                rsp_valid_r <= 1'b1;
                if (in_range_s) begin
                  rsp_data_r <= {6'd0, old_cell_s};
                  if ((cmd_op == OP_WRITE) || (old_cell_s == 3'd0)) begin
                    map_r[wr_off_s +: 3] <= cmd_data;
                  end
                end else begin
                  rsp_err_r <= 1'b1;
                end
              end
              default: begin
                val_r      <= cmd_data;
                is_count_r <= (cmd_op == OP_COUNT);
                idx_r      <= 9'd0;
                cnt_r      <= 9'd0;
              end
            endcase
          end
        end
        SWEEP: begin
          if (!is_count_r) begin
            map_r[sw_off_s +: 3] <= val_r;
          end else if (match_s) begin
            cnt_r <= cnt_r + 9'd1;
          end
          // The last cell's match is folded straight into the DONE response.
          if (idx_r == LAST_IDX) begin
            idx_r       <= 9'd0;
            rsp_valid_r <= 1'b1;
            if (is_count_r) begin
              rsp_data_r <= cnt_r + {8'd0, match_s};
            end else begin
              rsp_data_r <= 9'd0;
            end
          end else begin
            idx_r <= idx_r + 9'd1;
          end
        end
        DONE: begin
          idx_r <= 9'd0;
        end
        default: begin
          idx_r <= 9'd0;
        end
      endcase
    end
  end

endmodule
